// File: rtl/rx_frame_buffer_ctrl_if.sv
// Bus interface for rx_frame_buffer_ctrl: layer streams in, RX memory writes and slot status out.
// With RX_FRAME_TIMESTAMP_EN defined, the head-slot timestamp rx_head_ts is carried as well.
interface rx_frame_buffer_ctrl_if #(
  parameter int unsigned OCT        = 8,
  parameter int unsigned N_LAYER    = 3,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned SLOT_BYTES = 512
);
  localparam int unsigned SEL_W  = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned OFF_W  = $clog2(SLOT_BYTES);
  localparam int unsigned ADDR_W = SLOT_W + OFF_W;
  localparam int unsigned LEN_W  = OFF_W + 1;

  logic [SEL_W-1:0]       layer_sel;
  logic [N_LAYER-1:0]     rx_layer_data_v;
  logic [N_LAYER*OCT-1:0] rx_layer_data;
  logic                   rx_release;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [OCT-1:0]         mem_wdata;
  logic                   rx_irq;
  logic [SLOT_W:0]        rx_slot_count;
  logic [SLOT_W-1:0]      rx_head_slot;
  logic [LEN_W-1:0]       rx_head_len;
  logic [15:0]            rx_drop_cnt;
`ifdef RX_FRAME_TIMESTAMP_EN
  logic [31:0]            rx_head_ts;
`endif

  // Receive path / CPU side: drives streams and releases, observes buffer state
  modport master (
    output layer_sel, rx_layer_data_v, rx_layer_data, rx_release,
    input  mem_we, mem_addr, mem_wdata, rx_irq, rx_slot_count,
    input  rx_head_slot, rx_head_len, rx_drop_cnt
`ifdef RX_FRAME_TIMESTAMP_EN
    , input rx_head_ts
`endif
  );

  // Buffer controller side
  modport slave (
    input  layer_sel, rx_layer_data_v, rx_layer_data, rx_release,
    output mem_we, mem_addr, mem_wdata, rx_irq, rx_slot_count,
    output rx_head_slot, rx_head_len, rx_drop_cnt
`ifdef RX_FRAME_TIMESTAMP_EN
    , output rx_head_ts
`endif
  );
endinterface

// File: rtl/rx_frame_buffer_ctrl.sv
// RX frame buffer controller: muxes one of N_LAYER byte streams per frame into a ring of
// SLOTS fixed-size slots, tracks per-slot length, raises rx_irq while frames are pending and
// drops (and counts) frames arriving with the ring full or exceeding SLOT_BYTES.
// Optional macro RX_FRAME_TIMESTAMP_EN adds a per-slot first-byte cycle timestamp (rx_head_ts).
module rx_frame_buffer_ctrl #(
  parameter int unsigned OCT        = 8,
  parameter int unsigned N_LAYER    = 3,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned SLOT_BYTES = 512
) (
  input logic                   RX_CLK,
  input logic                   rst_n,
  rx_frame_buffer_ctrl_if.slave bus
);
  localparam int unsigned SEL_W  = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned OFF_W  = $clog2(SLOT_BYTES);
  localparam int unsigned ADDR_W = SLOT_W + OFF_W;
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam int unsigned CNT_W  = SLOT_W + 1;

  localparam logic [1:0] S_SKIP   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_RECV   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [SEL_W-1:0]  sel_q, sel_nxt, sel_use;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [SLOT_W-1:0] wr_ptr, rd_ptr, wr_slot;
  logic [CNT_W-1:0]  count, count_nxt, count_chk;
  logic [LEN_W-1:0]  len [SLOTS];
  logic [15:0]       drop_cnt;
  logic              dv;
  logic [OCT-1:0]    din;
  logic              wr_en, frame_start, drop_inc, commit, rel, full;
  logic [OFF_W-1:0]  wr_off;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [OCT-1:0]    mem_wdata_q;
  logic              irq_q;

  // Stream mux: a frame start looks at the requested layer, the rest of the frame at the latched one
  always_comb begin
    sel_use = (state == S_IDLE || state == S_COMMIT) ? bus.layer_sel : sel_q;
    dv      = 1'b0;
    din     = '0;
    for (int k = 0; k < N_LAYER; k++) begin
      if (sel_use == SEL_W'(k)) begin
        dv  = bus.rx_layer_data_v[k];
        din = bus.rx_layer_data[k*OCT +: OCT];
      end
    end
  end

  // Slot bookkeeping: commit/release arithmetic and the full check on the post-commit count
  always_comb begin
    commit    = (state == S_COMMIT);
    rel       = bus.rx_release && (count != '0);
    count_chk = commit ? CNT_W'(count + CNT_W'(1)) : count;
    full      = (count_chk == CNT_W'(SLOTS));
    wr_slot   = commit ? SLOT_W'(wr_ptr + SLOT_W'(1)) : wr_ptr;
    count_nxt = CNT_W'(count + CNT_W'(commit) - CNT_W'(rel));
  end

  // Next-state and write-request logic
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel_q;
    byte_cnt_nxt = byte_cnt;
    wr_en        = 1'b0;
    wr_off       = '0;
    drop_inc     = 1'b0;
    frame_start  = 1'b0;
    case (state)
      S_SKIP: begin
        if (!dv) state_nxt = S_IDLE;
      end
      S_IDLE, S_COMMIT: begin
        state_nxt = S_IDLE;
        if (dv) begin
          sel_nxt = bus.layer_sel;
          if (full) begin
            state_nxt = S_SKIP;
            drop_inc  = 1'b1;
          end else begin
            state_nxt    = S_RECV;
            wr_en        = 1'b1;
            byte_cnt_nxt = LEN_W'(1);
            frame_start  = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (!dv) begin
          state_nxt = S_COMMIT;
        end else if (byte_cnt == LEN_W'(SLOT_BYTES)) begin
          state_nxt = S_SKIP;
          drop_inc  = 1'b1;
        end else begin
          wr_en        = 1'b1;
          wr_off       = byte_cnt[OFF_W-1:0];
          byte_cnt_nxt = LEN_W'(byte_cnt + LEN_W'(1));
        end
      end
      default: state_nxt = S_SKIP;
    endcase
  end

  // State register; reset lands in S_SKIP so a frame in flight is ignored
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) state <= S_SKIP;
    else        state <= state_nxt;
  end

  // Datapath registers: pointers, count, lengths, drop counter and the memory write port
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      byte_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      irq_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < SLOTS; s++) len[s] <= '0;
    end else begin
      sel_q    <= sel_nxt;
      byte_cnt <= byte_cnt_nxt;
      count    <= count_nxt;
      irq_q    <= (count_nxt != '0);
      mem_we_q <= wr_en;
      if (wr_en) begin
        mem_addr_q  <= {wr_slot, wr_off};
        mem_wdata_q <= din;
      end
      if (commit) begin
        len[wr_ptr] <= byte_cnt;
        wr_ptr      <= SLOT_W'(wr_ptr + SLOT_W'(1));
      end
      if (rel) rd_ptr <= SLOT_W'(rd_ptr + SLOT_W'(1));
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef RX_FRAME_TIMESTAMP_EN
  logic [31:0] cyc, ts_pend;
  logic [31:0] ts [SLOTS];

  // Free-running cycle counter; first-byte stamp held until the frame commits
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      cyc     <= '0;
      ts_pend <= '0;
      for (int s = 0; s < SLOTS; s++) ts[s] <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (frame_start) ts_pend <= cyc;
      if (commit) ts[wr_ptr] <= ts_pend;
    end
  end

  assign bus.rx_head_ts = ts[rd_ptr];
`endif

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.rx_irq        = irq_q;
  assign bus.rx_slot_count = count;
  assign bus.rx_head_slot  = rd_ptr;
  assign bus.rx_head_len   = len[rd_ptr];
  assign bus.rx_drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// Directed bench for rx_frame_buffer_ctrl with a write scoreboard and a small slot model.
module tb_rx_frame_buffer_ctrl;
  localparam int SLOTS      = 4;
  localparam int SLOT_BYTES = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_frame_buffer_ctrl_if bus ();
  rx_frame_buffer_ctrl dut (.RX_CLK(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  m_wr, m_rd, m_cnt, m_drop;
  int  m_len [SLOTS];
  logic [31:0] tcyc;
  logic [31:0] ts_first;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcyc <= '0;
    else        tcyc <= tcyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Memory-write monitor: every mem_we must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (sb.size() == 0) begin
        check("spurious_we_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0; m_drop = 0;
    foreach (m_len[k]) m_len[k] = 0;
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.mem_we),        32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),      32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata),     32'd0);
    check({tag, "_count"}, 32'(bus.rx_slot_count), 32'd0);
    check({tag, "_irq"},   32'(bus.rx_irq),        32'd0);
    check({tag, "_head"},  32'(bus.rx_head_slot),  32'd0);
    check({tag, "_len"},   32'(bus.rx_head_len),   32'd0);
    check({tag, "_drop"},  32'(bus.rx_drop_cnt),   32'd0);
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.layer_sel       = '0;
    bus.rx_layer_data_v = '0;
    bus.rx_layer_data   = '0;
    bus.rx_release      = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, "_count"}, 32'(bus.rx_slot_count), 32'(m_cnt));
    check({tag, "_irq"},   32'(bus.rx_irq),        (m_cnt != 0) ? 32'd1 : 32'd0);
    check({tag, "_head"},  32'(bus.rx_head_slot),  32'(m_rd));
    check({tag, "_len"},   32'(bus.rx_head_len),   32'(m_len[m_rd]));
    check({tag, "_drop"},  32'(bus.rx_drop_cnt),   32'(m_drop));
    check({tag, "_sb"},    32'(sb.size()),         32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame on layer lay; sw_lay >= 0 also drives that layer and switches layer_sel mid-frame
  task automatic send(input int lay, input int n, input int base, input int sw_lay);
    logic acc;
    int   slot;
    acc  = (m_cnt < SLOTS);
    slot = m_wr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.layer_sel = 2'(lay);
        ts_first      = tcyc;
      end
      if (sw_lay >= 0 && i == n / 2) bus.layer_sel = 2'(sw_lay);
      bus.rx_layer_data_v = '0;
      bus.rx_layer_data   = '0;
      bus.rx_layer_data_v[lay] = 1'b1;
      bus.rx_layer_data[lay*8 +: 8] = 8'(base + i);
      if (sw_lay >= 0) begin
        bus.rx_layer_data_v[sw_lay] = 1'b1;
        bus.rx_layer_data[sw_lay*8 +: 8] = 8'(base + i) ^ 8'hA5;
      end
      if (acc && i < SLOT_BYTES) sb.push_back(wr_t'{addr: 11'(slot * SLOT_BYTES + i), data: 8'(base + i)});
    end
    @(posedge clk); #1;
    bus.rx_layer_data_v = '0;
    bus.rx_layer_data   = '0;
    if (acc && n <= SLOT_BYTES) begin
      m_len[slot] = n;
      m_wr  = (m_wr + 1) % SLOTS;
      m_cnt = m_cnt + 1;
    end else begin
      m_drop = m_drop + 1;
    end
  endtask

  task automatic release_slot();
    @(posedge clk); #1;
    bus.rx_release = 1'b1;
    if (m_cnt > 0) begin
      m_rd  = (m_rd + 1) % SLOTS;
      m_cnt = m_cnt - 1;
    end
    @(posedge clk); #1;
    bus.rx_release = 1'b0;
  endtask

  initial begin
    // Basic frame on the udp stream, release on empty ring ignored
    do_reset();
    check_model("reset");
    release_slot();
    check_model("rel_empty");
    send(2, 64, 0, -1);
    @(negedge clk);
    @(negedge clk);
    check("irq_before_commit", 32'(bus.rx_irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(bus.rx_irq), 32'd1);
    check_model("basic");

    // Layer select latched at frame start; next frame lands in slot 1
    do_reset();
    send(0, 40, 8'h10, 1);
    send(1, 16, 8'h80, -1);
    idle(3);
    check_model("layer");

    // Five frames with no release: fifth dropped, then a release reopens slot 0
    do_reset();
    for (int f = 0; f < 5; f++) send(1, 10, f * 16, -1);
    idle(3);
    check_model("full");
    release_slot();
    check_model("full_rel");
    send(1, 10, 8'h77, -1);
    idle(3);
    check_model("full_reuse");

    // Oversize frame dropped after 512 bytes, following frame reuses the slot
    do_reset();
    send(0, 600, 0, -1);
    send(0, 20, 8'h40, -1);
    idle(3);
    check_model("oversize");

    // Release coinciding with a commit at count 2, back-to-back frame during that commit
    do_reset();
    send(0, 8, 8'h00, -1);
    send(0, 8, 8'h20, -1);
    idle(3);
    check_model("simul_pre");
    send(0, 8, 8'h40, -1);
    fork
      begin
        release_slot();
        @(negedge clk);
        check("simul_count", 32'(bus.rx_slot_count), 32'd2);
        check("simul_head", 32'(bus.rx_head_slot), 32'd1);
      end
      send(2, 12, 8'h60, -1);
    join
    idle(3);
    check_model("simul_post");

    // Reset asserted at byte 30 of a frame in slot 1
    do_reset();
    send(0, 5, 8'h90, -1);
    idle(3);
    check_model("mid_pre");
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i == 31) rst_n = 1'b1;
      bus.layer_sel       = 2'd0;
      bus.rx_layer_data_v = 3'b001;
      bus.rx_layer_data   = {16'h0, 8'(8'hC0 + i)};
      if (i < 29) sb.push_back(wr_t'{addr: 11'(SLOT_BYTES + i), data: 8'(8'hC0 + i)});
      if (i == 30) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_sb", 32'(sb.size()), 32'd0);
        check_reset_outputs("mid_rst");
        model_reset();
      end
    end
    @(posedge clk); #1;
    bus.rx_layer_data_v = '0;
    bus.rx_layer_data   = '0;
    send(0, 25, 8'h30, -1);
    idle(3);
    check_model("mid_post");
`ifdef RX_FRAME_TIMESTAMP_EN
    check("head_ts", bus.rx_head_ts, ts_first);
`endif

    check("final_sb", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
